// File: rtl/ioiptest_pkg.sv
// Shared register offsets, response codes and helpers for the ioiptest AXI4-Lite slave.
package ioiptest_pkg;

    // Register word indices (byte address bits [3:2]).
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_OUT    = 2'd1;
    localparam logic [1:0] ADDR_IN     = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int unsigned CTRL_IRQ_EN_BIT = 0;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ioiptest_sync_edge.sv
// Two-flop synchronizer for asynchronous inputs followed by a rising-edge detector.
module ioiptest_sync_edge #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/ioiptest_s00_axi_regs.sv
// AXI4-Lite register block: CTRL, OUT, IN (synchronized input) and sticky RW1C STATUS.
module ioiptest_s00_axi_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   io_out,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   io_in,
    output logic                            irq
);

    import ioiptest_pkg::*;

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;

    logic          rdy_en_q;
    logic          aw_held_q;
    logic          w_held_q;
    logic [1:0]    aw_idx_q;
    logic [DW-1:0] w_data_q;
    logic [3:0]    w_strb_q;
    logic          bvalid_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0] out_q, out_d;
    logic [DW-1:0] status_q, status_d;
    logic          irq_q;

    logic          aw_ready, w_ready, ar_ready;
    logic          aw_hs, w_hs, ar_hs;
    logic          commit;
    logic [1:0]    wr_idx;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_mask;
    logic [DW-1:0] w1c;
    logic [DW-1:0] rd_mux;
    logic [DW-1:0] in_sync;
    logic [DW-1:0] in_rise;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    ioiptest_sync_edge #(
        .WIDTH (DW)
    ) u_sync_edge (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .async_in (io_in),
        .sync     (in_sync),
        .rise     (in_rise)
    );

    // READYs stay low while a response is pending or a channel is already held.
    assign aw_ready = rdy_en_q & ~aw_held_q & ~bvalid_q;
    assign w_ready  = rdy_en_q & ~w_held_q & ~bvalid_q;
    assign ar_ready = rdy_en_q & ~rvalid_q;

    assign aw_hs = S_AXI_AWVALID & aw_ready;
    assign w_hs  = S_AXI_WVALID & w_ready;
    assign ar_hs = S_AXI_ARVALID & ar_ready;

    // Commit once both halves are available, whether held or arriving this edge.
    assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[3:2];
    assign wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
    assign wr_mask = strb_to_mask(w_held_q ? w_strb_q : S_AXI_WSTRB);

    // Next-state for the writable registers; STATUS set beats W1C clear.
    always_comb begin
        ctrl_d = ctrl_q;
        out_d  = out_q;
        w1c    = '0;
        if (commit) begin
            case (wr_idx)
                ADDR_CTRL:   ctrl_d = (ctrl_q & ~wr_mask) | (wr_data & wr_mask);
                ADDR_OUT:    out_d  = (out_q & ~wr_mask) | (wr_data & wr_mask);
                ADDR_STATUS: w1c    = wr_data & wr_mask;
                default:     ; // IN is read-only; write is dropped but still acknowledged
            endcase
        end
        status_d = in_rise | (status_q & ~w1c);
    end

    // Read data selection from current (pre-update) register values.
    always_comb begin
        rd_mux = '0;
        case (S_AXI_ARADDR[3:2])
            ADDR_CTRL:   rd_mux = ctrl_q;
            ADDR_OUT:    rd_mux = out_q;
            ADDR_IN:     rd_mux = in_sync;
            ADDR_STATUS: rd_mux = status_q;
            default:     rd_mux = '0;
        endcase
    end

    // Write channel: holding registers, held flags and write response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdy_en_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_held_q <= 1'b1;
                if (w_hs)  w_held_q  <= 1'b1;
            end
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read channel: capture data on AR handshake and hold until RREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Register file and registered interrupt.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_q   <= '0;
            out_q    <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            out_q    <= out_d;
            status_q <= status_d;
            irq_q    <= ctrl_q[CTRL_IRQ_EN_BIT] & (|status_q);
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RVALID  = rvalid_q;
    assign io_out        = out_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_ioiptest_s00_axi_regs.sv
// Randomized self-checking bench for ioiptest_s00_axi_regs against a register-level model.
module tb_ioiptest_s00_axi_regs;

    logic        ACLK;
    logic        ARESETN;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] io_out;
    logic [31:0] io_in;
    logic        irq;

    ioiptest_s00_axi_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .io_out        (io_out),
        .io_in         (io_in),
        .irq           (irq)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: what software would see in each register.
    logic [31:0] m_ctrl, m_out, m_in, m_status;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_out = '0; m_in = '0; m_status = '0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) mask[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
        case (a[3:2])
            2'd0: m_ctrl = (m_ctrl & ~mask) | (d & mask);
            2'd1: m_out  = (m_out & ~mask) | (d & mask);
            2'd3: m_status = m_status & ~(d & mask);
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return m_ctrl;
            2'd1:    return m_out;
            2'd2:    return m_in;
            default: return m_status;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_ctrl[0] && (m_status != 0);
    endfunction

    // Change inputs and let them propagate through sync, edge capture and irq.
    task automatic drive_io(input logic [31:0] v);
        io_in = v;
        m_status = m_status | (v & ~m_in);
        m_in = v;
        repeat (5) @(posedge ACLK);
        #1;
    endtask

    // All transaction tasks start and end 1 time unit after a rising edge.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_hs, w_hs;
        int n;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        n = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
            @(negedge ACLK);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK);
            #1;
            if (aw_hs) S_AXI_AWVALID = 1'b0;
            if (w_hs)  S_AXI_WVALID  = 1'b0;
            n++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        @(negedge ACLK);
        check_eq("wr_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
        check_eq("wr_bresp", {30'b0, S_AXI_BRESP}, 32'd0);
        @(posedge ACLK);
        #1;
        model_write(a, d, s);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] data);
        bit hs;
        int n;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        hs = 0; n = 0;
        while (!hs && n < 20) begin
            @(negedge ACLK);
            hs = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        check_eq("rd_rvalid", {31'b0, S_AXI_RVALID}, 32'd1);
        check_eq("rd_rresp", {30'b0, S_AXI_RRESP}, 32'd0);
        data = S_AXI_RDATA;
        @(posedge ACLK);
        #1;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a);
        logic [31:0] d;
        axi_read(a, d);
        check_eq(tag, d, model_read(a));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d0;
        int bad;
        bit ok;
        logic [3:0] a;

        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        io_in = '0;
        model_reset();

        // Reset state
        #1;
        check_eq("rst_io_out", io_out, 32'd0);
        check_eq("rst_irq", {31'b0, irq}, 32'd0);
        check_eq("rst_readys", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
        check_eq("rst_valids", {30'b0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        check_eq("rel_ready_before", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
        @(posedge ACLK);
        #1;
        check_eq("rel_ready_after", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);

        // Sequential write then read-back of every register
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        axi_read(4'h0, d0); check_eq("seq_ctrl", d0, 32'h1);
        axi_read(4'h4, d0); check_eq("seq_out", d0, 32'h2);
        axi_read(4'h8, d0); check_eq("seq_in", d0, 32'h0);
        axi_read(4'hC, d0); check_eq("seq_status", d0, 32'h0);
        check_eq("seq_io_out", io_out, 32'h2);

        // Split write: AW at cycle 0, W at cycle 3, low half-word strobes
        S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        ok = S_AXI_AWREADY;
        @(posedge ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
        check_eq("split_aw_hs", {31'b0, ok}, 32'd1);
        bad = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'b0011; S_AXI_WVALID = 1'b1;
            end
            @(negedge ACLK);
            if (S_AXI_AWREADY !== 1'b0 || S_AXI_BVALID !== 1'b0) bad++;
            @(posedge ACLK);
            #1;
        end
        S_AXI_WVALID = 1'b0;
        check_eq("split_awready_low", bad, 0);
        @(negedge ACLK);
        check_eq("split_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
        check_eq("split_io_out", io_out, 32'h0000BEEF);
        @(posedge ACLK);
        #1;
        model_write(4'h4, 32'hDEADBEEF, 4'b0011);

        // Edge capture with irq_en set (CTRL already 1)
        io_in[5] = 1'b1;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        check_eq("edge_irq_k1", {31'b0, irq}, 32'd0);
        @(posedge ACLK); #1;
        check_eq("edge_irq_k2", {31'b0, irq}, 32'd0);
        @(posedge ACLK); #1;
        check_eq("edge_irq_k3", {31'b0, irq}, 32'd1);
        m_in = 32'h20; m_status = 32'h20;
        read_check("edge_status", 4'hC);
        read_check("edge_in", 4'h8);
        axi_write(4'hC, 32'h20, 4'hF);
        check_eq("clr_irq", {31'b0, irq}, 32'd0);
        read_check("clr_status", 4'hC);

        // Set/clear collision on STATUS bit 5
        drive_io(32'h0);
        io_in[5] = 1'b1;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h20; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        ok = S_AXI_AWREADY && S_AXI_WREADY;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check_eq("coll_hs", {31'b0, ok}, 32'd1);
        @(negedge ACLK);
        check_eq("coll_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
        @(posedge ACLK); #1;
        m_in = 32'h20; m_status = 32'h20;
        read_check("coll_status", 4'hC);
        check_eq("coll_irq", {31'b0, irq}, {31'b0, model_irq()});

        // Write response backpressure
        S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge ACLK);
            if (S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) bad++;
            @(posedge ACLK); #1;
        end
        check_eq("bp_write_stall", bad, 0);
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check_eq("bp_write_release", {30'b0, S_AXI_BVALID, S_AXI_AWREADY}, 32'd1);
        @(posedge ACLK); #1;
        model_write(4'h4, 32'h12345678, 4'hF);

        // Read response backpressure
        S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        d0 = S_AXI_RDATA;
        check_eq("bp_read_data", d0, m_out);
        bad = 0;
        repeat (10) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            if (S_AXI_RVALID !== 1'b1 || S_AXI_ARREADY !== 1'b0 || S_AXI_RDATA !== d0) bad++;
        end
        check_eq("bp_read_stall", bad, 0);
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check_eq("bp_read_release", {30'b0, S_AXI_RVALID, S_AXI_ARREADY}, 32'd1);
        @(posedge ACLK); #1;

        // Randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            a = {$urandom_range(0, 3), 2'b00};
            case ($urandom_range(0, 3))
                0: axi_write(a, $urandom, 4'($urandom));
                1: axi_write(a, $urandom, 4'hF);
                2: read_check("rnd_read", a);
                default: drive_io($urandom);
            endcase
            check_eq("rnd_io_out", io_out, m_out);
            check_eq("rnd_irq", {31'b0, irq}, {31'b0, model_irq()});
        end

        // Reset asserted in the middle of a write
        drive_io(32'h0);
        S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        #2;
        ARESETN = 1'b0;
        #1;
        S_AXI_AWVALID = 1'b0;
        check_eq("mid_rst_io_out", io_out, 32'd0);
        check_eq("mid_rst_rdata", S_AXI_RDATA, 32'd0);
        check_eq("mid_rst_flags",
                 {26'b0, irq, S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY,
                  S_AXI_ARREADY}, 32'd0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        model_reset();
        @(negedge ACLK);
        check_eq("mid_rel_before", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
        @(posedge ACLK); #1;
        check_eq("mid_rel_after", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);
        read_check("post_rst_ctrl", 4'h0);
        read_check("post_rst_out", 4'h4);
        read_check("post_rst_in", 4'h8);
        read_check("post_rst_status", 4'hC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ioiptest_s00_axi_regs.md
# ioiptest_s00_axi_regs

AXI4-Lite slave register block for the ioiptest IP, the stage that consumes the S00_AXI transactions issued by the bench's master VIP agent. It exposes four 32-bit registers that control a 32-bit output port, sample a 32-bit input port, and record input rising edges as sticky status bits. A level interrupt is derived from the status bits. All responses are OKAY.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; only bits [3:2] are decoded.

Ports:
- ACLK  in  1  the single clock; all state is on its rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  4/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  4/3/1/1  read address channel; ARPROT is ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data channel.
- io_out  out  32  equals the OUT register.
- io_in  in  32  asynchronous inputs.
- irq  out  1  registered level interrupt.

## Operation
- Register map:
  - 0x0 CTRL, RW; bit0 is irq_en, other bits are stored and read back.
  - 0x4 OUT, RW; drives io_out.
  - 0x8 IN, RO; returns the synchronized io_in. Writes are dropped and respond OKAY.
  - 0xC STATUS, RW1C; bit n sets on a synchronized io_in[n] rising edge.
- WSTRB applies per byte to CTRL, OUT and STATUS. For STATUS, only bits under an active strobe that are written 1 are cleared.
- Write path:
  - AW and W are accepted independently into holding registers (aw_held, w_held).
  - AWREADY = rdy_en & !aw_held & !BVALID. WREADY = rdy_en & !w_held & !BVALID.
  - The commit happens at the edge where both address and data are available, whether held or handshaking this edge. At that edge the register updates, BVALID rises, both held flags clear, and BRESP = 00.
  - BVALID holds until BREADY is sampled high.
- Read path:
  - ARREADY = rdy_en & !RVALID.
  - On an AR handshake, RDATA and RVALID are registered at that edge with RRESP = 00. They hold until RREADY.
- Input path: io_in passes through a 2-flop synchronizer into IN, then a delay flop. Edge = sync & ~prev.
- STATUS update per bit: if edge, the bit sets; else if W1C, the bit clears. Set wins over clear in the same cycle.
- irq = CTRL[0] & |STATUS, registered.
- The read and write channels are fully independent. A STATUS read in the same cycle as a W1C commit returns the pre-clear value.

## Timing
- Reset (ARESETN low, asynchronous): all registers, held flags, BVALID, RVALID, RDATA, io_out, irq, sync flops and rdy_en go to 0. All READY outputs are 0 during reset.
- rdy_en is a flop that sets 1 at the first edge after ARESETN release, so READYs go high one cycle after release.
- Write latency: the commit edge is the handshake edge of the later of AW and W. The register value and BVALID are visible immediately after that edge.
- Back-to-back write throughput: one write per 2 cycles with BREADY held high.
- Read latency: RVALID is visible after the AR handshake edge. Throughput is one read per 2 cycles.
- io_in step before edge k:
  - IN updates after edge k+1.
  - The STATUS bit sets after edge k+2.
  - irq rises after edge k+3, if irq_en is set.
- Reset asserted mid-transaction: the transaction is abandoned with no response. The master must restart.

## Structure
- Shared package ioiptest_pkg holds:
  - Register offsets ADDR_CTRL/OUT/IN/STATUS (2-bit indices).
  - RESP_OKAY = 2'b00.
  - CTRL_IRQ_EN_BIT = 0.
- One sub-module, ioiptest_sync_edge: parameterized width, 2-flop synchronizer plus edge detect, outputs sync and rise.

## Test plan
- Sequential write/read: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back.
  - Required: CTRL = 1, OUT = 2, IN = current io_in (0), STATUS = 0. io_out = 0x2. All responses OKAY.
- Split write: AW at cycle 0, W at cycle 3 to OUT with data 0xDEADBEEF and WSTRB = 4'b0011.
  - Required: AWREADY low for cycles 1–3, BVALID after the cycle-3 edge, io_out = 0x0000BEEF.
- Edge capture: with irq_en = 1, toggle io_in[5] 0→1.
  - Required: STATUS = 0x20 three edges later, irq = 1 one edge later.
  - Then write 0x20 to STATUS: STATUS = 0 and irq drops the cycle after.
- Set/clear collision: a W1C of bit 5 commits on the same edge a new bit-5 edge is detected.
  - Required: STATUS[5] stays 1.
- Backpressure: hold BREADY/RREADY low for 10 cycles.
  - Required: BVALID/RVALID and RDATA stable, and AWREADY/WREADY/ARREADY stay low until the response handshake.
- Reset: assert ARESETN mid-write.
  - Required: all outputs 0 immediately, READYs high one cycle after release, all registers read 0.
